// File: rtl/amba3_apb_sram_slave.sv
// AMBA 3 APB slave fronting a word-addressed SRAM bank with programmable wait states.
// Tracks completed transfers and flags out-of-range accesses (sticky until reset).
module amba3_apb_sram_slave #(
  parameter int                    ADDR_SIZE   = 32,
  parameter int                    DATA_SIZE   = 32,
  parameter int                    DEPTH       = 16,
  parameter logic [ADDR_SIZE-1:0]  BASE_ADDR   = '0,
  parameter int                    WAIT_CYCLES = 0
) (
  input  logic                 pclk,
  input  logic                 preset,
  input  logic [ADDR_SIZE-1:0] paddr,
  input  logic                 psel,
  input  logic                 penable,
  input  logic                 pwrite,
  input  logic [DATA_SIZE-1:0] pwdata,
  output logic                 pready,
  output logic [DATA_SIZE-1:0] prdata,
  output logic                 oor_flag,
  output logic [15:0]          xfer_count
);

  localparam int BYTES   = DATA_SIZE / 8;
  localparam int IDX_LSB = $clog2(BYTES);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_SIZE:0] SPAN = (ADDR_SIZE+1)'(DEPTH * BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t               r_state, w_state_nxt;
  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [IDX_W-1:0]     r_idx;
  logic                 r_in_range;
  logic                 r_write;
  logic [3:0]           r_cnt;
  logic                 r_pready;
  logic [DATA_SIZE-1:0] r_prdata;
  logic                 r_oor;
  logic [15:0]          r_xfer_count;

  logic [ADDR_SIZE:0]   w_off;
  logic                 w_in_range;
  logic [IDX_W-1:0]     w_idx;
  logic [IDX_W-1:0]     w_rd_idx;
  logic                 w_rd_ok;
  logic                 w_setup;
  logic                 w_load;
  logic                 w_done;
  logic                 w_abort;

  // Offset wraps to a huge value when paddr < BASE_ADDR, so one compare covers both bounds.
  assign w_off      = {1'b0, paddr} - {1'b0, BASE_ADDR};
  assign w_in_range = (w_off < SPAN);
  assign w_idx      = paddr[IDX_LSB +: IDX_W];
  assign w_setup    = psel && !penable;

  // With no wait states, read data is loaded on the setup edge straight from the bus address.
  assign w_rd_idx = (r_state == S_IDLE) ? w_idx : r_idx;
  assign w_rd_ok  = (r_state == S_IDLE) ? (w_in_range && !pwrite) : (r_in_range && !r_write);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_setup) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt = S_ACCESS;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (penable && r_cnt == 4'd1) begin
          w_state_nxt = S_ACCESS;
          w_load      = 1'b1;
        end
      end
      S_ACCESS: begin
        if (!psel) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (penable && r_pready) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      r_idx        <= '0;
      r_in_range   <= 1'b0;
      r_write      <= 1'b0;
      r_cnt        <= '0;
      r_pready     <= 1'b0;
      r_prdata     <= '0;
      r_oor        <= 1'b0;
      r_xfer_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (r_state == S_IDLE && w_setup) begin
        r_idx      <= w_idx;
        r_in_range <= w_in_range;
        r_write    <= pwrite;
        r_cnt      <= 4'(WAIT_CYCLES);
      end
      if (r_state == S_WAIT && psel && penable) r_cnt <= r_cnt - 4'd1;
      if (w_load) begin
        r_pready <= 1'b1;
        r_prdata <= w_rd_ok ? r_mem[w_rd_idx] : '0;
      end
      if (w_done) begin
        if (r_write && r_in_range) r_mem[r_idx] <= pwdata;
        if (!r_in_range) r_oor <= 1'b1;
        r_xfer_count <= r_xfer_count + 16'd1;
      end
      if (w_done || w_abort) begin
        r_pready <= 1'b0;
        r_prdata <= '0;
      end
    end
  end

  assign pready     = r_pready;
  assign prdata     = r_prdata;
  assign oor_flag   = r_oor;
  assign xfer_count = r_xfer_count;

endmodule

// File: tb/tb_amba3_apb_sram_slave.sv
// Bench for amba3_apb_sram_slave: three instances (0, 3 and 2 wait states) driven by
// an APB master task, read data checked against a queue of model-predicted values.
module tb_amba3_apb_sram_slave;

  logic        pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        preset  [3];
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic        pready  [3];
  logic [31:0] prdata  [3];
  logic        oor     [3];
  logic [15:0] xcnt    [3];

  amba3_apb_sram_slave #(.WAIT_CYCLES(0)) u_w0 (
    .pclk(pclk), .preset(preset[0]), .paddr(paddr[0]), .psel(psel[0]),
    .penable(penable[0]), .pwrite(pwrite[0]), .pwdata(pwdata[0]),
    .pready(pready[0]), .prdata(prdata[0]), .oor_flag(oor[0]), .xfer_count(xcnt[0]));

  amba3_apb_sram_slave #(.WAIT_CYCLES(3)) u_w3 (
    .pclk(pclk), .preset(preset[1]), .paddr(paddr[1]), .psel(psel[1]),
    .penable(penable[1]), .pwrite(pwrite[1]), .pwdata(pwdata[1]),
    .pready(pready[1]), .prdata(prdata[1]), .oor_flag(oor[1]), .xfer_count(xcnt[1]));

  amba3_apb_sram_slave #(.WAIT_CYCLES(2)) u_w2 (
    .pclk(pclk), .preset(preset[2]), .paddr(paddr[2]), .psel(psel[2]),
    .penable(penable[2]), .pwrite(pwrite[2]), .pwdata(pwdata[2]),
    .pready(pready[2]), .prdata(prdata[2]), .oor_flag(oor[2]), .xfer_count(xcnt[2]));

  logic [31:0] mem_m [3][16];
  logic [15:0] xc_m  [3];
  logic        oor_m [3];
  logic [31:0] exp_q [$];
  int          n_pass = 0;
  int          n_chk  = 0;

  function automatic int wc(input int u);
    return (u == 0) ? 0 : (u == 1) ? 3 : 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Entered and left #1 after a rising edge, so consecutive calls run back to back.
  task automatic xfer(input int u, input logic [31:0] addr, input logic wr,
                      input logic [31:0] data);
    int   lows = 0;
    bit   seen = 0;
    logic [31:0] e;
    psel[u] = 1'b1; penable[u] = 1'b0; paddr[u] = addr; pwrite[u] = wr;
    pwdata[u] = wr ? ~data : data;
    if (!wr) exp_q.push_back((addr < 32'h40) ? mem_m[u][addr[5:2]] : 32'h0);
    @(negedge pclk);
    check("setup_rdy", 32'(pready[u]), 32'h0);
    @(posedge pclk); #1;
    penable[u] = 1'b1;
    paddr[u]   = addr ^ 32'h4;
    pwrite[u]  = ~wr;
    pwdata[u]  = data;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge pclk);
      if (pready[u]) begin
        seen = 1;
        check("wait_len", 32'(lows), 32'(wc(u)));
        if (!wr) begin
          e = exp_q.pop_front();
          check("rdata", prdata[u], e);
        end
      end else begin
        lows++;
        check("prdata_lo", prdata[u], 32'h0);
      end
    end
    if (!seen) begin
      check("timeout", 32'h0, 32'h1);
      if (!wr && exp_q.size() > 0) e = exp_q.pop_front();
    end
    @(posedge pclk); #1;
    if (seen) begin
      xc_m[u]++;
      if (addr >= 32'h40) oor_m[u] = 1'b1;
      else if (wr) mem_m[u][addr[5:2]] = data;
    end
    psel[u] = 1'b0; penable[u] = 1'b0;
    check("done_rdy", 32'(pready[u]), 32'h0);
    check("done_rd0", prdata[u], 32'h0);
    check("xcnt", 32'(xcnt[u]), 32'(xc_m[u]));
    check("oor", 32'(oor[u]), 32'(oor_m[u]));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    longint t0;
    bit     hit;
    for (int u = 0; u < 3; u++) begin
      preset[u] = 1'b1; psel[u] = 1'b0; penable[u] = 1'b0; pwrite[u] = 1'b0;
      paddr[u] = '0; pwdata[u] = '0; xc_m[u] = '0; oor_m[u] = 1'b0;
      for (int i = 0; i < 16; i++) mem_m[u][i] = '0;
    end
    repeat (2) @(posedge pclk);
    #1;
    for (int u = 0; u < 3; u++) begin
      check("rst_rdy", 32'(pready[u]), 32'h0);
      check("rst_rd",  prdata[u], 32'h0);
      check("rst_oor", 32'(oor[u]), 32'h0);
      check("rst_cnt", 32'(xcnt[u]), 32'h0);
      preset[u] = 1'b0;
    end
    @(posedge pclk); #1;

    // Zero wait states: write/read, then an unwritten word
    xfer(0, 32'h04, 1'b1, 32'hDEADBEEF);
    xfer(0, 32'h04, 1'b0, 32'h0);
    check("cnt_two", 32'(xcnt[0]), 32'h2);
    xfer(0, 32'h08, 1'b0, 32'h0);

    // Out of range: no memory effect, sticky flag, counted
    xfer(0, 32'h40, 1'b1, 32'hFFFFFFFF);
    check("oor_set", 32'(oor[0]), 32'h1);
    xfer(0, 32'h40, 1'b0, 32'h0);
    for (int i = 0; i < 16; i++) xfer(0, 32'(i * 4), 1'b0, 32'h0);

    // Back to back, two cycles per transfer
    t0 = $time;
    xfer(0, 32'h00, 1'b1, 32'hA5A5_0001);
    xfer(0, 32'h3C, 1'b1, 32'h5A5A_003C);
    xfer(0, 32'h00, 1'b0, 32'h0);
    xfer(0, 32'h3C, 1'b0, 32'h0);
    check("b2b_time", 32'($time - t0), 32'd80);

    // Three wait states
    xfer(1, 32'h00, 1'b1, 32'h12345678);
    xfer(1, 32'h00, 1'b0, 32'h0);

    // Abort in WAIT with two wait states
    xfer(2, 32'h08, 1'b1, 32'h0000_0055);
    psel[2] = 1'b1; penable[2] = 1'b0; paddr[2] = 32'h08; pwrite[2] = 1'b1; pwdata[2] = 32'hAA;
    @(posedge pclk); #1;
    penable[2] = 1'b1;
    @(posedge pclk); #1;
    check("abort_rdy_wait", 32'(pready[2]), 32'h0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    @(posedge pclk); #1;
    check("abort_rdy", 32'(pready[2]), 32'h0);
    check("abort_cnt", 32'(xcnt[2]), 32'(xc_m[2]));
    xfer(2, 32'h08, 1'b0, 32'h0);

    // Asynchronous reset during ACCESS of a write
    psel[1] = 1'b1; penable[1] = 1'b0; paddr[1] = 32'h10; pwrite[1] = 1'b1; pwdata[1] = 32'h77;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    hit = 0;
    for (int k = 0; k < 20 && !hit; k++) begin
      @(negedge pclk);
      hit = pready[1];
    end
    check("rst_reach_access", 32'(hit), 32'h1);
    preset[1] = 1'b1;
    #1;
    check("rst_async_rdy", 32'(pready[1]), 32'h0);
    check("rst_async_cnt", 32'(xcnt[1]), 32'h0);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    preset[1] = 1'b0;
    xc_m[1] = '0; oor_m[1] = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[1][i] = '0;
    xfer(1, 32'h10, 1'b0, 32'h0);
    xfer(1, 32'h00, 1'b0, 32'h0);

    // Counter wrap, preloaded near the top
    force u_w0.r_xfer_count = 16'hFFFE;
    #1;
    release u_w0.r_xfer_count;
    xc_m[0] = 16'hFFFE;
    @(posedge pclk); #1;
    xfer(0, 32'h00, 1'b0, 32'h0);
    xfer(0, 32'h04, 1'b0, 32'h0);
    check("wrap_zero", 32'(xcnt[0]), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/amba3_apb_sram_slave.md
# amba3_apb_sram_slave

Synthesizable AMBA 3 APB slave: a word-addressed register/SRAM bank with programmable wait states. It sits directly downstream of the APB master port of `amba3_apb_if` and consumes `paddr/psel/penable/pwrite/pwdata`. It returns `pready/prdata` with the same handshake the interface master tasks expect. It is the RTL target the interface's master tasks drive in block-level benches.

## Interface
- `ADDR_SIZE`, 32: address width.
- `DATA_SIZE`, 32: data width; multiple of 8.
- `DEPTH`, 16: number of words; power of two, ≥2.
- `BASE_ADDR`, 0: byte address of word 0; aligned to `DEPTH*DATA_SIZE/8`.
- `WAIT_CYCLES`, 0: wait states inserted per transfer, 0..15.
- `pclk` in 1: clock; all state updates on the rising edge.
- `preset` in 1: reset, asynchronous and active-high (one clock; reset is asynchronous and active-high).
- `paddr` in `ADDR_SIZE`: byte address.
- `psel` in 1: slave select.
- `penable` in 1: access phase.
- `pwrite` in 1: 1 = write, 0 = read.
- `pwdata` in `DATA_SIZE`: write data.
- `pready` out 1: transfer completes on the rising edge where `psel & penable & pready`.
- `prdata` out `DATA_SIZE`: read data; valid only while `pready=1` on a read; 0 otherwise.
- `oor_flag` out 1: sticky; set by any out-of-range transfer; cleared only by reset.
- `xfer_count` out 16: completed-transfer counter; wraps 0xFFFF→0x0000.

## Operation
- Word index = `paddr[log2(DATA_SIZE/8) +: log2(DEPTH)]`.
- In range iff `BASE_ADDR <= paddr < BASE_ADDR + DEPTH*DATA_SIZE/8`. Low byte-offset bits are ignored.
- Reset: state IDLE, `pready=0`, `prdata=0`, `oor_flag=0`, `xfer_count=0`, wait counter 0, all memory words 0.
- FSM states: IDLE, WAIT, ACCESS.
- IDLE:
  - On an edge with `psel=1, penable=0` (setup phase), latch `paddr` and `pwrite`.
  - If `WAIT_CYCLES=0`: go to ACCESS, drive `pready<=1`, and for a read drive `prdata<=mem[idx]`.
  - Otherwise: go to WAIT with `cnt<=WAIT_CYCLES`.
- WAIT: on each edge with `psel & penable`, decrement `cnt`. On the edge where `cnt==1`: go to ACCESS, `pready<=1`, load `prdata` for reads.
- ACCESS: on the edge with `psel & penable & pready`:
  - Write: commit `mem[idx] <= pwdata` (skipped if out of range).
  - `xfer_count++`.
  - Set `oor_flag` if out of range.
  - `pready<=0`, `prdata<=0`, return to IDLE.
- An out-of-range read returns `prdata=0`. An out-of-range write changes no memory.
- Read data is captured from the latched address when `pready` rises. A write and a read to the same word in consecutive transfers returns the new data.
- Protocol abort: `psel=0` seen in WAIT or ACCESS → IDLE, `pready=0`, `prdata=0`. No write, no count, no flag.
- `paddr`, `pwrite`, and `pwdata` changes during WAIT/ACCESS are ignored; the setup-phase address and direction are used. `pwdata` is sampled at the completion edge.

## Timing
- Access phase lasts exactly `WAIT_CYCLES+1` cycles with `penable=1`. `pready` is low for the first `WAIT_CYCLES` of them.
- `pready` and `prdata` are registered; there is no combinational path from inputs to outputs.
- Back-to-back transfers: the completion edge returns to IDLE, so the next setup phase (the following cycle) is accepted with no bubble. Minimum 2 cycles per transfer with `WAIT_CYCLES=0`.
- `xfer_count` and `oor_flag` update on the completion edge and are visible the cycle after.
- Reset asserted mid-transfer: outputs go to reset values immediately (asynchronously). A write in flight is not committed.

## Test plan
- Reset with `WAIT_CYCLES=0`: write 0xDEADBEEF to 0x04, then read 0x04 → `pready` high during the first access cycle, `prdata=0xDEADBEEF`, `xfer_count=2`. A read of 0x08 returns 0.
- `WAIT_CYCLES=3`: read 0x00 after a write of 0x12345678 → `pready` low for 3 access cycles, high on the 4th; `prdata=0` until `pready` rises.
- Out-of-range: write 0xFFFFFFFF to 0x40 (DEPTH 16), then read 0x40 → `prdata=0`, `oor_flag=1` from the cycle after the first completion, words 0..15 unchanged, `xfer_count` increments twice.
- Back-to-back: writes to 0x00 and 0x3C, then reads of both with no idle cycles → 2 cycles per transfer; data returned matches each address.
- Abort and reset: drop `psel` during WAIT (`WAIT_CYCLES=2`) → no write, count unchanged. Assert `preset` mid-ACCESS of a write → `pready=0` immediately; memory word still 0 after reset.
- Counter wrap: preload the counter via 65,536 transfers (or force in a short bench) → `xfer_count` reads 0x0000 after transfer 65,536.
